// File: rtl/signed_addsub_pipe.sv
// Two-stage pipelined signed add/subtract unit with an internal accumulator,
// wrap or saturate arithmetic, result flags and valid/ready handshakes on
// both the input and output sides.
module signed_addsub_pipe #(
    parameter int WIDTH       = 4,
    parameter bit SAT_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_sat,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic [WIDTH-1:0] acc_val
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             sat_mode;
    logic [WIDTH-1:0] acc;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_res;
    logic             s1_ovf;
    logic             s2_valid;

    logic             s2_adv;
    logic             accept;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] x_op;
    logic [WIDTH-1:0] y_op;
    logic [WIDTH:0]   x_ext;
    logic [WIDTH:0]   y_ext;
    logic [WIDTH:0]   raw;
    logic             raw_ovf;
    logic [WIDTH-1:0] raw_res;

    // Handshake and stage-advance conditions
    always_comb begin
        s2_adv    = !s2_valid || out_ready;
        in_ready  = !s1_valid || s2_adv;
        accept    = in_valid && in_ready;
        out_valid = s2_valid;
        acc_val   = acc;
    end

    // Operand selection, extended add/sub, overflow detection and saturation
    always_comb begin
        // A clear in the same cycle makes an accumulator op see zero
        acc_eff = acc_clr ? '0 : acc;
        x_op    = in_op[1] ? acc_eff : in_a;
        y_op    = in_op[1] ? in_a : in_b;
        x_ext   = {x_op[WIDTH-1], x_op};
        y_ext   = {y_op[WIDTH-1], y_op};
        raw     = in_op[0] ? (x_ext - y_ext) : (x_ext + y_ext);
        // Out of range exactly when the two top bits of the extended sum disagree
        raw_ovf = raw[WIDTH] ^ raw[WIDTH-1];
        if (raw_ovf && (in_sat || sat_mode)) begin
            raw_res = raw[WIDTH] ? MIN_NEG : MAX_POS;
        end else begin
            raw_res = raw[WIDTH-1:0];
        end
    end

    // Saturate-mode bit, loaded from its default at reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_mode <= SAT_DEFAULT;
        end else begin
            sat_mode <= sat_mode;
        end
    end

    // Accumulator: written by accepted accumulator ops, otherwise cleared on request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept && in_op[1]) begin
            acc <= raw_res;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    // Stage 1: capture computed result on acceptance, drain when stage 2 takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_res   <= '0;
            s1_ovf   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= accept;
            if (accept) begin
                s1_res <= raw_res;
                s1_ovf <= raw_ovf;
            end
        end
    end

    // Stage 2: output register with flags, holds while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_res  <= '0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
            out_neg  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_res  <= s1_res;
                out_ovf  <= s1_ovf;
                out_zero <= (s1_res == '0);
                out_neg  <= s1_res[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_signed_addsub_pipe.sv
// Self-checking bench for signed_addsub_pipe: directed cases followed by
// randomized traffic, checked against an integer-arithmetic reference model.
module tb_signed_addsub_pipe;

    localparam int W    = 4;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [1:0]   in_op;
    logic         in_sat;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         out_ovf;
    logic         out_zero;
    logic         out_neg;
    logic [W-1:0] acc_val;

    signed_addsub_pipe #(.WIDTH(W), .SAT_DEFAULT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_sat(in_sat),
        .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg),
        .acc_val(acc_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        bit ovf;
    } exp_t;

    exp_t expq[$];
    int   model_acc;
    int   vectors;
    int   miscompares;
    bit   last_accept;
    int   last_res;
    bit   last_ovf;
    bit   last_zero;
    bit   last_neg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v > MAXV) ? v - (1 << W) : v;
    endfunction

    // Reference: signed integer arithmetic, range test, then clamp or truncate
    function automatic exp_t model(input int op, input int a, input int b,
                                   input bit sat, input int accv);
        exp_t e;
        int x, y, raw;
        x     = (op >= 2) ? sx(accv) : sx(a);
        y     = (op >= 2) ? sx(a) : sx(b);
        raw   = (op % 2 == 1) ? x - y : x + y;
        e.ovf = (raw > MAXV) || (raw < MINV);
        if (sat && e.ovf) raw = (raw > 0) ? MAXV : MINV;
        e.res = raw & MASK;
        return e;
    endfunction

    // One clock: observe handshakes mid-cycle, update scoreboard, then step past the edge
    task automatic tick();
        exp_t e;
        int   accx;
        @(negedge clk);
        last_accept = 1'b0;
        if (rst_n) begin
            check("acc_val", 32'(acc_val), 32'(model_acc));
            if (out_valid && out_ready) begin
                check("out_expected", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("out_res", 32'(out_res), 32'(e.res));
                    check("out_ovf", 32'(out_ovf), 32'(e.ovf));
                    check("out_zero", 32'(out_zero), 32'(e.res == 0));
                    check("out_neg", 32'(out_neg), 32'((e.res >> (W - 1)) & 1));
                    last_res  = int'(out_res);
                    last_ovf  = out_ovf;
                    last_zero = out_zero;
                    last_neg  = out_neg;
                end
            end
            if (in_valid && in_ready) begin
                accx = acc_clr ? 0 : model_acc;
                e = model(int'(in_op), int'(in_a), int'(in_b), in_sat, accx);
                expq.push_back(e);
                if (in_op[1]) model_acc = e.res;
                else if (acc_clr) model_acc = 0;
                last_accept = 1'b1;
            end else if (acc_clr) begin
                model_acc = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] op, input logic sat,
                            input int exp_res, input bit exp_ovf);
        int n;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_sat = sat;
        n = 0;
        do begin tick(); n++; end while (!last_accept && n < 10);
        check({tag, "_accepted"}, 32'(last_accept), 32'd1);
        in_valid = 1'b0;
        n = 0;
        while (expq.size() > 0 && n < 10) begin tick(); n++; end
        check({tag, "_drained"}, 32'(expq.size()), 32'd0);
        check({tag, "_res"}, 32'(last_res), 32'(exp_res));
        check({tag, "_ovf"}, 32'(last_ovf), 32'(exp_ovf));
    endtask

    initial begin
        int n, idx, acc_cnt;
        logic [W-1:0] bp_a [4];
        vectors = 0; miscompares = 0; model_acc = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00;
        in_sat = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_res", 32'(out_res), 32'd0);
        check("rst_acc", 32'(acc_val), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 4+4 wraps to -8 with overflow; exact latency check
        in_valid = 1'b1; in_a = 4'b0100; in_b = 4'b0100; in_op = 2'b00; in_sat = 1'b0;
        tick();
        check("lat_accept", 32'(last_accept), 32'd1);
        in_valid = 1'b0;
        check("lat_not_early", 32'(out_valid), 32'd0);
        tick();
        check("lat_valid", 32'(out_valid), 32'd1);
        tick();
        check("wrap_res", 32'(last_res), 32'h8);
        check("wrap_ovf", 32'(last_ovf), 32'd1);
        check("wrap_neg", 32'(last_neg), 32'd1);

        // Saturation and non-overflow boundaries
        send_one("sat_add", 4'b0100, 4'b0100, 2'b00, 1'b1, 7, 1'b1);
        check("sat_add_zero", 32'(last_zero), 32'd0);
        send_one("sat_sub", 4'b0111, 4'b1000, 2'b01, 1'b1, 7, 1'b1);
        send_one("wrap_sub", 4'b0111, 4'b1000, 2'b01, 1'b0, 15, 1'b1);
        send_one("add_small", 4'b0000, 4'b0001, 2'b00, 1'b0, 1, 1'b0);
        send_one("sub_minneg", 4'b1111, 4'b0111, 2'b01, 1'b0, 8, 1'b0);
        check("sub_minneg_neg", 32'(last_neg), 32'd1);
        send_one("sub_zero", 4'b0101, 4'b0101, 2'b01, 1'b0, 0, 1'b0);
        check("sub_zero_flag", 32'(last_zero), 32'd1);

        // Back-to-back saturating accumulate, then clear coinciding with ACC-A
        in_valid = 1'b1; in_a = 4'b0101; in_op = 2'b10; in_sat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("acc_b2b_accept", 32'(last_accept), 32'd1);
        end
        check("acc_sat7", 32'(acc_val), 32'd7);
        acc_clr = 1'b1; in_a = 4'b0010; in_op = 2'b11;
        tick();
        check("acc_clr_accept", 32'(last_accept), 32'd1);
        acc_clr = 1'b0; in_valid = 1'b0;
        n = 0;
        while (expq.size() > 0 && n < 10) begin tick(); n++; end
        check("acc_clr_res", 32'(last_res), 32'hE);
        check("acc_clr_val", 32'(acc_val), 32'hE);

        // Backpressure: only two beats fit while the output is stalled
        bp_a[0] = 4'd1; bp_a[1] = 4'd2; bp_a[2] = 4'd3; bp_a[3] = 4'd4;
        out_ready = 1'b0; idx = 0; acc_cnt = 0;
        in_op = 2'b00; in_b = 4'd1; in_sat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = bp_a[idx];
            if (i == 2) check("bp_in_ready_low", 32'(in_ready), 32'd0);
            tick();
            if (last_accept) begin idx++; acc_cnt++; end
        end
        check("bp_accepted2", 32'(acc_cnt), 32'd2);
        out_ready = 1'b1;
        n = 0;
        while ((idx < 4 || expq.size() > 0) && n < 30) begin
            in_valid = (idx < 4);
            if (idx < 4) in_a = bp_a[idx];
            tick();
            if (last_accept) idx++;
            n++;
        end
        in_valid = 1'b0;
        check("bp_all_sent", 32'(idx), 32'd4);
        check("bp_all_out", 32'(expq.size()), 32'd0);

        // Reset with both stages full and acc=5
        out_ready = 1'b0;
        in_valid = 1'b1; acc_clr = 1'b1; in_op = 2'b10; in_a = 4'd5; in_sat = 1'b0;
        tick();
        acc_clr = 1'b0; in_op = 2'b00; in_a = 4'd1; in_b = 4'd1;
        tick();
        in_valid = 1'b0;
        check("pre_rst_acc5", 32'(acc_val), 32'd5);
        check("pre_rst_full", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_acc", 32'(acc_val), 32'd0);
        expq.delete();
        model_acc = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end

        // Randomized traffic with random backpressure and clears
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && !last_accept)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a     = W'($urandom);
                in_b     = W'($urandom);
                in_op    = 2'($urandom);
                in_sat   = 1'($urandom);
            end
            acc_clr   = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        n = 0;
        while (expq.size() > 0 && n < 20) begin tick(); n++; end
        check("rand_drained", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/signed_addsub_pipe.md
Name: signed_addsub_pipe

Overview:
Parametrised, pipelined signed add/subtract unit, the next generation of the team's 4-bit combinational signed adder/subtractor.
- Adds an operand width parameter, an internal accumulator, and selectable wrap or saturate arithmetic.
- Produces overflow, zero and negative flags.
- Uses valid/ready handshakes on input and output, so it can sit between the pad-level input register and downstream result consumers with backpressure.

Parameters:
WIDTH, 4, operand/result width in bits, two's complement, legal range 2..32
SAT_DEFAULT, 0, reset value of the internal saturate-mode bit (0 = wrap, 1 = saturate)

Ports:
clk  in  1  system clock, all state rising-edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  unit can accept a beat this cycle
in_a  in  WIDTH  signed operand A
in_b  in  WIDTH  signed operand B (ignored for accumulator ops)
in_op  in  2  00 A+B, 01 A-B, 10 ACC+A, 11 ACC-A
in_sat  in  1  per-beat saturate enable, OR-ed with the internal SAT bit
acc_clr  in  1  synchronous accumulator clear, independent of handshake
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
out_res  out  WIDTH  signed result
out_ovf  out  1  signed overflow occurred, evaluated before saturation
out_zero  out  1  out_res == 0
out_neg  out  1  out_res MSB
acc_val  out  WIDTH  current accumulator contents

Behaviour:
- Reset (async assert, sync-safe deassert): S1/S2 valid=0; out_res, flags, acc = 0; SAT bit = SAT_DEFAULT; in_ready = 1 from the first cycle after deassert.
- Handshakes:
  - Input accepted when in_valid && in_ready.
  - Output transferred when out_valid && out_ready.
  - Held data must not change while valid && !ready.
- Pipeline: two register stages.
  - S1 (compute) and S2 (output).
  - S2 advances when !S2.valid || out_ready.
  - S1 advances into S2 whenever S2 advances.
  - in_ready = !S1.valid || S2 advance condition (combinational, no in_valid dependency).
- Latency: accepted on edge N, out_valid high after edge N+1 (visible in cycle N+1), given no stall. Throughput 1 beat/cycle with out_ready held high.
- Arithmetic at acceptance: operands sign-extended to WIDTH+1; raw = X ± Y where X = in_a (op 0x) or acc (op 1x).
- Overflow: ovf = 1 when raw is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Result:
  - Saturate active, ovf=1: result = max positive if raw>0, else min negative.
  - Wrap: result = raw[WIDTH-1:0].
- Accumulator:
  - Accepted op 1x writes the result (post wrap/sat) into acc on the same edge it is captured into S1.
  - Back-to-back accumulator ops therefore chain with no bubble.
  - Ops 0x never modify acc.
- acc_clr:
  - Clears acc on the next edge.
  - If it coincides with an accepted op 1x, the op uses acc=0 as X and acc takes that op's result.
- Flags: zero/neg derived from the final result, registered with it into S2.
- Stall: while !out_ready with S2 full, S1 holds. in_ready falls when both stages are full; no beat is lost or duplicated.
- Reset mid-operation: all in-flight beats discarded, acc cleared, no out_valid pulse after release.

Test Plan:
- WIDTH=4, sat off: A=0100, B=0100, op 00, out_ready=1 -> result 1000 (-8), ovf=1, neg=1, out_valid exactly 2 cycles after acceptance.
- Same beat with in_sat=1 -> result 0111 (7), ovf=1, zero=0; then A=0111, B=1000, op 01 sat -> 0111, ovf=1; wrap -> 1111, ovf=1.
- Non-overflow cases:
  - A=0000, B=0001, op 00 -> 0001, ovf=0.
  - A=1111, B=0111, op 01 -> 1000 (-8), ovf=0, neg=1.
  - A=0101, B=0101, op 01 -> 0000, zero=1.
- Accumulate with sat, acc=0: three back-to-back op 10 beats, A=0101 -> results 5 (ovf=0), 7 (ovf=1), 7 (ovf=1); acc_val=7.
  - acc_clr together with a fourth op 11, A=0010 -> result -2, acc_val=1110.
- Backpressure: out_ready=0, 4 consecutive in_valid beats -> exactly 2 accepted, in_ready=0 on the third.
  - Release out_ready -> results emerge in order, then remaining beats accepted; none lost.
- Assert rst_n low with both stages full and acc=5 -> out_valid=0, acc_val=0, in_ready=1 one cycle after release, no stale output.
